// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer measurement stage.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RAND = 3'd1,
        GO        = 3'd2,
        RESULT    = 3'd3,
        EARLY     = 3'd4,
        TIMEOUT   = 3'd5
    } state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          DELAY_W   = 13;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; shared with the display path.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q,
    output logic        at_max
);

    logic [15:0] q_next;
    logic        carry;

    always_comb begin
        q_next = q;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    q_next[4*i +: 4] = 4'd0;
                end else begin
                    q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 16'h0000;
        else if (clr)
            q <= 16'h0000;
        else if (inc)
            q <= q_next;
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction trial FSM: random pre-GO delay, then millisecond BCD count until the press.
// Optional macro BEST_TIME_EN adds a best_bcd output tracking the fastest valid result.
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1k,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        led_go,
    output logic [15:0] result_bcd,
    output logic        done,
    output logic        too_soon,
    output logic        timeout,
    output logic [2:0]  state_dbg
`ifdef BEST_TIME_EN
    ,
    output logic [15:0] best_bcd
`endif
);

    state_t               state;
    logic [DELAY_W-1:0]   delay_cnt;
    logic [DELAY_W-1:0]   delay_load;
    logic [15:0]          lfsr;
    logic [2:0]           sync_p0, sync_p1, sync_p2;
    logic                 ms_tick, start_p, react_p;
    logic                 restart, go_now, cnt_clr, cnt_inc, cnt_max;

    // Stage boundary: two-flop synchronisers plus edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 3'b000;
            sync_p1 <= 3'b000;
            sync_p2 <= 3'b000;
        end else begin
            sync_p0 <= {clk1k, start_btn, react_btn};
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign ms_tick = sync_p1[2] & ~sync_p2[2];
    assign start_p = sync_p1[1] & ~sync_p2[1];
    assign react_p = sync_p1[0] & ~sync_p2[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_next(lfsr);
    end

    assign delay_load = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr[RAND_BITS-1:0]);

    assign restart = start_p && (state == IDLE || state == RESULT ||
                                 state == EARLY || state == TIMEOUT);
    assign go_now  = (state == WAIT_RAND) && !react_p && ms_tick &&
                     (delay_cnt == DELAY_W'(1));
    assign cnt_clr = restart || go_now;
    // A press in the same cycle as a tick freezes the count without incrementing
    assign cnt_inc = (state == GO) && ms_tick && !react_p && !cnt_max;

    bcd_counter4 u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .q      (result_bcd),
        .at_max (cnt_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            delay_cnt <= '0;
            led_go    <= 1'b0;
            done      <= 1'b0;
            too_soon  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE, RESULT, EARLY, TIMEOUT: begin
                    if (start_p) begin
                        state     <= WAIT_RAND;
                        delay_cnt <= delay_load;
                        led_go    <= 1'b0;
                        done      <= 1'b0;
                        too_soon  <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                WAIT_RAND: begin
                    if (react_p) begin
                        state    <= EARLY;
                        too_soon <= 1'b1;
                    end else if (ms_tick) begin
                        if (delay_cnt == DELAY_W'(1)) begin
                            state  <= GO;
                            led_go <= 1'b1;
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_W'(1);
                        end
                    end
                end
                GO: begin
                    if (react_p) begin
                        state  <= RESULT;
                        done   <= 1'b1;
                        led_go <= 1'b0;
                    end else if (ms_tick && cnt_max) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                        led_go  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

`ifdef BEST_TIME_EN
    // Counter is frozen on the RESULT entry cycle, so result_bcd is the final time here
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            best_bcd <= BCD_MAX;
        else if (state == GO && react_p && result_bcd < best_bcd)
            best_bcd <= result_bcd;
    end
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: table of trials scored through a queue, plus corner sequences.
module tb_reaction_timer_core;

    localparam int MIN_D = 20;
    localparam int RB    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk1k = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        led_go;
    logic [15:0] result_bcd;
    logic        done, too_soon, timeout;
    logic [2:0]  state_dbg;
`ifdef BEST_TIME_EN
    logic [15:0] best_bcd;
`endif

    int checks = 0;
    int errors = 0;
    int half   = 10;

    typedef struct {
        int          react_ticks;
        bit          early;
        logic [15:0] exp_result;
        logic [2:0]  exp_state;
        logic        exp_done;
        logic        exp_soon;
        logic        exp_to;
        logic [15:0] exp_best;
    } trial_t;

    trial_t sb[$];
    trial_t tbl[4];

    reaction_timer_core #(.MIN_DELAY_MS(MIN_D), .RAND_BITS(RB)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk1k      (clk1k),
        .start_btn  (start_btn),
        .react_btn  (react_btn),
        .led_go     (led_go),
        .result_bcd (result_bcd),
        .done       (done),
        .too_soon   (too_soon),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
`ifdef BEST_TIME_EN
        ,
        .best_bcd   (best_bcd)
`endif
    );

    always #5 clk = ~clk;

    always begin
        repeat (half) @(negedge clk);
        clk1k = ~clk1k;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_btn = 1'b1;
        repeat (4) @(negedge clk);
        start_btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_go(output int ticks, output bit ok);
        logic prev;
        ticks = 0;
        ok    = 1'b0;
        prev  = clk1k;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (clk1k && !prev) ticks++;
            prev = clk1k;
            if (led_go) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_flag(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done || too_soon || timeout) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic score(input string tag);
        trial_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty queue expected entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_result"}, result_bcd, e.exp_result);
        check({tag, "_state"}, {13'd0, state_dbg}, {13'd0, e.exp_state});
        check({tag, "_done"}, done, e.exp_done);
        check({tag, "_too_soon"}, too_soon, e.exp_soon);
        check({tag, "_timeout"}, timeout, e.exp_to);
        check({tag, "_led_go"}, led_go, 1'b0);
`ifdef BEST_TIME_EN
        check({tag, "_best"}, best_bcd, e.exp_best);
`endif
    endtask

    task automatic run_trial(input trial_t t, input string tag);
        int   ticks;
        bit   ok;
        logic seen_go;
        logic prev;
        int   r;
        sb.push_back(t);
        pulse_start();
        if (t.early) begin
            seen_go = 1'b0;
            prev    = clk1k;
            r       = 0;
            while (r < t.react_ticks) begin
                @(posedge clk); #1;
                seen_go |= led_go;
                if (clk1k && !prev) r++;
                prev = clk1k;
            end
            repeat (8) @(negedge clk);
            react_btn = 1'b1;
            wait_flag(100, ok);
            seen_go |= led_go;
            check({tag, "_led_never"}, seen_go, 1'b0);
        end else begin
            wait_go(ticks, ok);
            check({tag, "_go_seen"}, ok, 1'b1);
            check({tag, "_delay_range"}, (ticks >= MIN_D - 4 && ticks <= MIN_D + (1 << RB)), 1'b1);
            repeat (t.react_ticks) @(posedge clk1k);
            repeat (8) @(negedge clk);
            react_btn = 1'b1;
            wait_flag(100, ok);
        end
        check({tag, "_flag_seen"}, ok, 1'b1);
        repeat (3) @(negedge clk);
        react_btn = 1'b0;
        repeat (2) @(negedge clk);
        score(tag);
    endtask

    initial begin
        int   ticks;
        bit   ok;
        trial_t t;

        tbl[0] = '{300, 1'b0, 16'h0300, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0300};
        tbl[1] = '{250, 1'b0, 16'h0250, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0250};
        tbl[2] = '{400, 1'b0, 16'h0400, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0250};
        tbl[3] = '{10,  1'b1, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b0, 16'h0250};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_state", {13'd0, state_dbg}, 16'd0);
        check("rst_led", led_go, 1'b0);
        check("rst_result", result_bcd, 16'h0000);
        check("rst_flags", {done, too_soon, timeout}, 3'b000);
`ifdef BEST_TIME_EN
        check("rst_best", best_bcd, 16'h9999);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_trial(tbl[i], $sformatf("trial%0d", i));

        // Restart from EARLY clears too_soon and re-enters WAIT_RAND
        pulse_start();
        @(posedge clk); #1;
        check("restart_state", {13'd0, state_dbg}, 16'd1);
        check("restart_too_soon", too_soon, 1'b0);
        check("restart_led", led_go, 1'b0);

        // Press coincident with the tick that would roll 0099 to 0100
        t = '{0, 1'b0, 16'h0099, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0099};
        sb.push_back(t);
        wait_go(ticks, ok);
        check("simul_go_seen", ok, 1'b1);
        repeat (99) @(posedge clk1k);
        @(posedge clk1k);
        react_btn = 1'b1;
        wait_flag(100, ok);
        check("simul_flag_seen", ok, 1'b1);
        repeat (30) @(negedge clk);
        react_btn = 1'b0;
        score("simul");

        // Asynchronous reset in the middle of a GO count
        pulse_start();
        wait_go(ticks, ok);
        check("midrst_go_seen", ok, 1'b1);
        repeat (123) @(posedge clk1k);
        repeat (8) @(negedge clk);
        check("midrst_pre_count", result_bcd, 16'h0123);
        #2 rst = 1'b1;
        #1;
        check("midrst_async_led", led_go, 1'b0);
        check("midrst_async_result", result_bcd, 16'h0000);
        @(posedge clk); #1;
        check("midrst_state", {13'd0, state_dbg}, 16'd0);
        check("midrst_flags", {done, too_soon, timeout, led_go}, 4'b0000);
        check("midrst_result", result_bcd, 16'h0000);
`ifdef BEST_TIME_EN
        check("midrst_best", best_bcd, 16'h9999);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Timeout with no press; fast tick rate keeps run time short
        half = 1;
        repeat (25) @(negedge clk);
        pulse_start();
        wait_go(ticks, ok);
        check("to_go_seen", ok, 1'b1);
        wait_flag(25000, ok);
        check("to_flag_seen", ok, 1'b1);
        repeat (2) @(negedge clk);
        check("to_timeout", timeout, 1'b1);
        check("to_result", result_bcd, 16'h9999);
        check("to_led", led_go, 1'b0);
        check("to_state", {13'd0, state_dbg}, 16'd5);
        check("to_done", done, 1'b0);
        repeat (40) @(negedge clk);
        check("to_hold", result_bcd, 16'h9999);
`ifdef BEST_TIME_EN
        check("to_best", best_bcd, 16'h9999);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Measurement stage fed by the 1 kHz divider output clk1k. Runs one reaction trial:
- waits a pseudo-random delay;
- lights the GO LED;
- counts elapsed milliseconds until the react button is pressed.

Result is presented as 4-digit BCD to the display-driver stage. All logic runs on clk; clk1k is treated as data, synchronised and edge-detected, never used as a clock.

Parameters:
MIN_DELAY_MS, 1000, fixed part of random pre-GO delay in ms
RAND_BITS, 11, LFSR bits added to delay (0..2^RAND_BITS-1 ms)
LFSR_SEED, 16'hACE1, non-zero reset value of 16-bit LFSR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk1k  in  1  1 kHz square wave from divider (asynchronous to this logic's view)
start_btn  in  1  debounced level, start trial
react_btn  in  1  debounced level, player reaction
led_go  out  1  GO indicator
result_bcd  out  16  {thousands,hundreds,tens,ones} ms, BCD
done  out  1  valid result held
too_soon  out  1  react pressed before GO
timeout  out  1  count reached 9999 without press
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async, any state): FSM=IDLE; led_go=0, result_bcd=0, done=0, too_soon=0, timeout=0; LFSR=LFSR_SEED; all synchronisers 0.
- clk1k path: 2-FF synchroniser plus rising-edge detect gives ms_tick, a 1-clk pulse. Latency from clk1k rise is 3 clk.
- Buttons: 2-FF synchroniser plus rising-edge detect each, giving start_p and react_p (1-clk pulses). Held levels do not retrigger.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every clk, never stalls.
- FSM states:
  - IDLE(0): start_p -> WAIT_RAND. On the transition:
    - load delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0];
    - clear result_bcd and all flags.
  - WAIT_RAND(1): ms_tick decrements delay_cnt.
    - react_p -> EARLY (too_soon=1).
    - Else delay_cnt==1 on a ms_tick -> GO. In the same cycle: led_go=1, result_bcd=0.
  - GO(2): ms_tick increments BCD counter (ones digit wraps 9->0 with carry into the next digit, and so on).
    - react_p -> RESULT (done=1, led_go=0). The counter freezes.
    - Counter==9999 on a ms_tick -> TIMEOUT (timeout=1, led_go=0, result_bcd holds 9999).
  - RESULT(3) / EARLY(4) / TIMEOUT(5): outputs held. start_p -> WAIT_RAND with a fresh delay load and flags cleared.
- Simultaneous events:
  - react_p and ms_tick in the same cycle in GO: press wins, no increment.
  - react_p and the expiring ms_tick in WAIT_RAND: EARLY.
- start_p is ignored in WAIT_RAND and GO. react_p is ignored in IDLE/RESULT/EARLY/TIMEOUT.
- Flags done/too_soon/timeout are mutually exclusive levels, not pulses.
- delay_cnt width is 13 bits: max 1000+2047=3047 fits.

Optional Feature:
BEST_TIME_EN:
- Defined: adds output best_bcd[15:0].
  - Reset value 16'h9999.
  - On entry to RESULT, best_bcd updates to result_bcd if result_bcd < best_bcd. Comparison is digit-wise BCD, equivalent to unsigned compare of the packed 16 bits.
  - EARLY/TIMEOUT never update it.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Package reaction_pkg:
  - state enum/localparams (IDLE..TIMEOUT, 3 bits);
  - BCD_MAX=16'h9999;
  - LFSR tap mask;
  - DELAY_W=13.
- Sub-module bcd_counter4 (clr, inc, q[15:0], at_max): natural reuse with the display path.
- Synchroniser/edge-detect inlined or as a tiny sync_edge helper.

Test Plan:
- Reset mid-GO with counter at 0x0123 -> next clk state_dbg=0, led_go=0, result_bcd=0, all flags 0.
- Bench drives clk1k period 20 clk; start_p, press react 250 ticks after led_go rises -> done=1, result_bcd=16'h0250, state_dbg=3.
- react_p 10 ticks after start (before GO) -> too_soon=1, led_go never 1, state_dbg=4; a second start_p restarts WAIT_RAND with too_soon cleared.
- No press after GO -> after 9999 ticks timeout=1, result_bcd=16'h9999, led_go=0.
- react_p in the same clk as ms_tick in GO at count 0x0099 -> result_bcd stays 0x0099 (no roll to 0x0100).
- BEST_TIME_EN: trials of 0x0300, 0x0250, 0x0400 -> best_bcd 0x0300, 0x0250, 0x0250; an EARLY trial leaves 0x0250.
